// File: rtl/lsu_bus_initiator_if.sv
// Bundles the core request/completion channel and the dr/dw data bus of the
// load/store unit. The master side is the bus initiator; the slave side is the
// core together with the memory responder.
interface lsu_bus_if #(
    parameter int RESP_WIDTH = 2
);
    // core request
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [2:0]            req_funct3;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    // core completion
    logic                  done_valid;
    logic [1:0]            done_err;
    logic [31:0]           done_rdata;
    // data read channel
    logic                  dr_addr_valid;
    logic                  dr_addr_ready;
    logic [31:0]           dr_addr;
    logic                  dr_data_valid;
    logic                  dr_data_ready;
    logic [31:0]           dr_data;
    // data write channel
    logic                  dw_data_addr_valid;
    logic                  dw_data_addr_ready;
    logic [31:0]           dw_addr;
    logic [31:0]           dw_data;
    logic [3:0]            dw_strobe;
    logic                  dw_resp_valid;
    logic                  dw_resp_ready;
    logic [RESP_WIDTH-1:0] dw_resp;

    modport master (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready,
        output done_valid, done_err, done_rdata,
        output dr_addr_valid, dr_addr, dr_data_ready,
        input  dr_addr_ready, dr_data_valid, dr_data,
        output dw_data_addr_valid, dw_addr, dw_data, dw_strobe, dw_resp_ready,
        input  dw_data_addr_ready, dw_resp_valid, dw_resp
    );

    modport slave (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready,
        input  done_valid, done_err, done_rdata,
        input  dr_addr_valid, dr_addr, dr_data_ready,
        output dr_addr_ready, dr_data_valid, dr_data,
        input  dw_data_addr_valid, dw_addr, dw_data, dw_strobe, dw_resp_ready,
        output dw_data_addr_ready, dw_resp_valid, dw_resp
    );
endinterface

// File: rtl/lsu_bus_initiator.sv
// Data-side bus initiator of the copperv core. Accepts one load/store at a
// time, issues a word-aligned transfer on dr or dw with byte strobes, and
// returns extended load data plus an error code as a one-cycle done pulse.
module lsu_bus_initiator #(
    parameter int RESP_WIDTH = 2,
    parameter int RESP_OK    = 0,
    parameter int TIMEOUT    = 255
) (
    input logic       clk,
    input logic       rst,
    lsu_bus_if.master bus
);

    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP} state_t;

    localparam logic [1:0]            ERR_OK       = 2'd0;
    localparam logic [1:0]            ERR_MISALIGN = 2'd1;
    localparam logic [1:0]            ERR_BUS      = 2'd2;
    localparam logic [1:0]            ERR_TIMEOUT  = 2'd3;
    localparam logic [7:0]            TIMEOUT_LIM  = 8'(TIMEOUT);
    localparam logic [RESP_WIDTH-1:0] RESP_OK_V    = RESP_WIDTH'(RESP_OK);

    state_t     state;
    logic [2:0] funct3_q;
    logic [1:0] off_q;
    logic [7:0] wait_cnt;
    logic       expire;

    // Size is funct3[1:0]: 00 byte, 01 half, anything else is a word access.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = off[0];
            default: misaligned = (off != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] lane_strobe(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   lane_strobe = 4'b0001 << off;
            2'b01:   lane_strobe = 4'b0011 << off;
            default: lane_strobe = 4'b1111;
        endcase
    endfunction

    // Replicating the low bytes puts the store data on every lane, so the
    // strobe alone selects where it lands.
    function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] wdata);
        case (f3[1:0])
            2'b00:   lane_data = {4{wdata[7:0]}};
            2'b01:   lane_data = {2{wdata[15:0]}};
            default: lane_data = wdata;
        endcase
    endfunction

    // funct3[2] selects zero extension (BU/HU); otherwise sign extension.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [31:0]        sh;
        logic signed [7:0]  b_s;
        logic signed [15:0] h_s;
        sh  = word >> {off, 3'b000};
        b_s = sh[7:0];
        h_s = sh[15:0];
        case (f3[1:0])
            2'b00:   load_extend = f3[2] ? {24'b0, sh[7:0]}  : 32'(b_s);
            2'b01:   load_extend = f3[2] ? {16'b0, sh[15:0]} : 32'(h_s);
            default: load_extend = word;
        endcase
    endfunction

    // A pending handshake gives up on the cycle the wait count reaches TIMEOUT.
    assign expire = (TIMEOUT != 0) && (wait_cnt == TIMEOUT_LIM - 8'd1);

    // Requests are taken only when idle and out of reset.
    assign bus.req_ready = rst && (state == IDLE);

    // Transaction sequencer with registered bus and completion outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state                  <= IDLE;
            funct3_q               <= 3'b0;
            off_q                  <= 2'b0;
            wait_cnt               <= 8'd0;
            bus.done_valid         <= 1'b0;
            bus.done_err           <= ERR_OK;
            bus.done_rdata         <= 32'b0;
            bus.dr_addr_valid      <= 1'b0;
            bus.dr_addr            <= 32'b0;
            bus.dr_data_ready      <= 1'b0;
            bus.dw_data_addr_valid <= 1'b0;
            bus.dw_addr            <= 32'b0;
            bus.dw_data            <= 32'b0;
            bus.dw_strobe          <= 4'b0;
            bus.dw_resp_ready      <= 1'b0;
        end else begin
            bus.done_valid <= 1'b0;
            bus.done_err   <= ERR_OK;
            bus.done_rdata <= 32'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        funct3_q <= bus.req_funct3;
                        off_q    <= bus.req_addr[1:0];
                        wait_cnt <= 8'd0;
                        if (misaligned(bus.req_funct3, bus.req_addr[1:0])) begin
                            bus.done_valid <= 1'b1;
                            bus.done_err   <= ERR_MISALIGN;
                        end else if (bus.req_write) begin
                            state                  <= WREQ;
                            bus.dw_data_addr_valid <= 1'b1;
                            bus.dw_addr            <= {bus.req_addr[31:2], 2'b00};
                            bus.dw_data            <= lane_data(bus.req_funct3, bus.req_wdata);
                            bus.dw_strobe          <= lane_strobe(bus.req_funct3, bus.req_addr[1:0]);
                        end else begin
                            state             <= RADDR;
                            bus.dr_addr_valid <= 1'b1;
                            bus.dr_addr       <= {bus.req_addr[31:2], 2'b00};
                        end
                    end
                end
                RADDR: begin
                    if (bus.dr_addr_ready) begin
                        state             <= RDATA;
                        bus.dr_addr_valid <= 1'b0;
                        bus.dr_data_ready <= 1'b1;
                        wait_cnt          <= 8'd0;
                    end else if (expire) begin
                        state             <= IDLE;
                        bus.dr_addr_valid <= 1'b0;
                        bus.done_valid    <= 1'b1;
                        bus.done_err      <= ERR_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RDATA: begin
                    if (bus.dr_data_valid) begin
                        state             <= IDLE;
                        bus.dr_data_ready <= 1'b0;
                        bus.done_valid    <= 1'b1;
                        bus.done_rdata    <= load_extend(funct3_q, off_q, bus.dr_data);
                    end else if (expire) begin
                        state             <= IDLE;
                        bus.dr_data_ready <= 1'b0;
                        bus.done_valid    <= 1'b1;
                        bus.done_err      <= ERR_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                WREQ: begin
                    if (bus.dw_data_addr_ready) begin
                        state                  <= WRESP;
                        bus.dw_data_addr_valid <= 1'b0;
                        bus.dw_resp_ready      <= 1'b1;
                        wait_cnt               <= 8'd0;
                    end else if (expire) begin
                        state                  <= IDLE;
                        bus.dw_data_addr_valid <= 1'b0;
                        bus.done_valid         <= 1'b1;
                        bus.done_err           <= ERR_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                WRESP: begin
                    if (bus.dw_resp_valid) begin
                        state             <= IDLE;
                        bus.dw_resp_ready <= 1'b0;
                        bus.done_valid    <= 1'b1;
                        bus.done_err      <= (bus.dw_resp != RESP_OK_V) ? ERR_BUS : ERR_OK;
                    end else if (expire) begin
                        state             <= IDLE;
                        bus.dw_resp_ready <= 1'b0;
                        bus.done_valid    <= 1'b1;
                        bus.done_err      <= ERR_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_initiator.sv
// Directed bench for lsu_bus_initiator: a small strobe-aware memory responder
// with stall / mute / error knobs, and a linear sequence of load/store steps.
module tb_lsu_bus_initiator;

    logic clk;
    logic rst;

    lsu_bus_if #(.RESP_WIDTH(2)) bus ();

    lsu_bus_initiator #(
        .RESP_WIDTH(2),
        .RESP_OK   (0),
        .TIMEOUT   (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // responder knobs
    logic        rd_ready_en;
    logic        wr_ready_en;
    logic        resp_mute;
    logic [1:0]  resp_code;
    logic        pre_we;
    logic [31:0] pre_addr;
    logic [31:0] pre_data;
    logic [31:0] mem [0:1023];

    assign bus.dr_addr_ready      = rd_ready_en;
    assign bus.dw_data_addr_ready = wr_ready_en;

    // Memory responder: data/response valid the cycle after the address handshake.
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr[11:2]] <= pre_data;
        if (!rst) begin
            bus.dr_data_valid <= 1'b0;
            bus.dw_resp_valid <= 1'b0;
            bus.dr_data       <= 32'b0;
            bus.dw_resp       <= 2'b0;
        end else begin
            if (bus.dr_data_valid && bus.dr_data_ready) bus.dr_data_valid <= 1'b0;
            if (bus.dr_addr_valid && bus.dr_addr_ready) begin
                bus.dr_data_valid <= 1'b1;
                bus.dr_data       <= mem[bus.dr_addr[11:2]];
            end
            if (bus.dw_resp_valid && bus.dw_resp_ready) bus.dw_resp_valid <= 1'b0;
            if (bus.dw_data_addr_valid && bus.dw_data_addr_ready) begin
                for (int i = 0; i < 4; i++)
                    if (bus.dw_strobe[i]) mem[bus.dw_addr[11:2]][8*i +: 8] <= bus.dw_data[8*i +: 8];
                bus.dw_resp_valid <= !resp_mute;
                bus.dw_resp       <= resp_code;
            end
        end
    end

    int n_pass;
    int n_total;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        tick();
        pre_we   = 1'b0;
    endtask

    // Present a request in IDLE and let it be accepted on the next edge.
    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        bus.req_write  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        check("req_ready_at_issue", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid  = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!bus.done_valid && k < 40) begin
            tick();
            k++;
        end
        check("done_seen", 32'(bus.done_valid), 32'h1);
    endtask

    task automatic do_op(input string tag, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rdata, input logic [1:0] exp_err);
        issue(wr, f3, a, wd);
        wait_done();
        check({tag, "_rdata"}, bus.done_rdata, exp_rdata);
        check({tag, "_err"}, 32'(bus.done_err), 32'(exp_err));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int hold;
        int wresp_cycles;
        n_pass = 0; n_total = 0; n_fail = 0;
        rst = 1'b0;
        rd_ready_en = 1'b1; wr_ready_en = 1'b1; resp_mute = 1'b0; resp_code = 2'd0;
        pre_we = 1'b0; pre_addr = 32'b0; pre_data = 32'b0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'b0;
        bus.req_addr = 32'b0; bus.req_wdata = 32'b0;

        // reset state
        tick();
        preload(32'h100, 32'h11223344);
        preload(32'h200, 32'h11223344);
        check("rst_req_ready", 32'(bus.req_ready), 32'h0);
        check("rst_dr_addr_valid", 32'(bus.dr_addr_valid), 32'h0);
        check("rst_dw_valid", 32'(bus.dw_data_addr_valid), 32'h0);
        check("rst_done_valid", 32'(bus.done_valid), 32'h0);
        rst = 1'b1;
        tick();
        check("idle_req_ready", 32'(bus.req_ready), 32'h1);

        // LW 0x100, cycle by cycle against the zero-wait responder
        issue(1'b0, 3'b010, 32'h100, 32'h0);
        check("lw_raddr_valid", 32'(bus.dr_addr_valid), 32'h1);
        check("lw_raddr", bus.dr_addr, 32'h100);
        check("lw_raddr_data_ready", 32'(bus.dr_data_ready), 32'h0);
        check("lw_busy_req_ready", 32'(bus.req_ready), 32'h0);
        tick();
        check("lw_rdata_addr_valid", 32'(bus.dr_addr_valid), 32'h0);
        check("lw_rdata_data_ready", 32'(bus.dr_data_ready), 32'h1);
        check("lw_rdata_done", 32'(bus.done_valid), 32'h0);
        tick();
        check("lw_done_valid", 32'(bus.done_valid), 32'h1);
        check("lw_done_rdata", bus.done_rdata, 32'h11223344);
        check("lw_done_err", 32'(bus.done_err), 32'h0);
        check("lw_done_req_ready", 32'(bus.req_ready), 32'h1);
        check("lw_done_data_ready", 32'(bus.dr_data_ready), 32'h0);
        tick();
        check("lw_done_pulse_ends", 32'(bus.done_valid), 32'h0);

        // word store, then sub-word loads with sign/zero extension
        do_op("sw_100", 1'b1, 3'b010, 32'h100, 32'h80FF7F01, 32'h0, 2'd0);
        do_op("lb_103", 1'b0, 3'b000, 32'h103, 32'h0, 32'hFFFFFF80, 2'd0);
        do_op("lbu_103", 1'b0, 3'b100, 32'h103, 32'h0, 32'h00000080, 2'd0);
        do_op("lh_102", 1'b0, 3'b001, 32'h102, 32'h0, 32'hFFFF80FF, 2'd0);
        do_op("lhu_102", 1'b0, 3'b101, 32'h102, 32'h0, 32'h000080FF, 2'd0);
        do_op("lb_100", 1'b0, 3'b000, 32'h100, 32'h0, 32'h00000001, 2'd0);
        do_op("lres_100", 1'b0, 3'b011, 32'h100, 32'h0, 32'h80FF7F01, 2'd0);

        // SB 0x201: lane shift and strobe
        issue(1'b1, 3'b000, 32'h201, 32'h123456AB);
        check("sb_dw_valid", 32'(bus.dw_data_addr_valid), 32'h1);
        check("sb_dw_addr", bus.dw_addr, 32'h200);
        check("sb_dw_strobe", 32'(bus.dw_strobe), 32'h2);
        check("sb_dw_data", bus.dw_data, 32'hABABABAB);
        wait_done();
        check("sb_err", 32'(bus.done_err), 32'h0);
        check("sb_rdata", bus.done_rdata, 32'h0);
        do_op("lw_200_after_sb", 1'b0, 3'b010, 32'h200, 32'h0, 32'h1122AB44, 2'd0);

        // SH 0x202
        issue(1'b1, 3'b001, 32'h202, 32'h0000BEEF);
        check("sh_dw_strobe", 32'(bus.dw_strobe), 32'hC);
        check("sh_dw_data", bus.dw_data, 32'hBEEFBEEF);
        wait_done();
        check("sh_err", 32'(bus.done_err), 32'h0);
        do_op("lw_200_after_sh", 1'b0, 3'b010, 32'h200, 32'h0, 32'hBEEFAB44, 2'd0);

        // misaligned: no bus activity, error on the next cycle
        issue(1'b0, 3'b010, 32'h102, 32'h0);
        check("mis_lw_no_dr", 32'(bus.dr_addr_valid), 32'h0);
        check("mis_lw_done", 32'(bus.done_valid), 32'h1);
        check("mis_lw_err", 32'(bus.done_err), 32'h1);
        check("mis_lw_rdata", bus.done_rdata, 32'h0);
        check("mis_lw_req_ready", 32'(bus.req_ready), 32'h1);
        issue(1'b1, 3'b001, 32'h301, 32'h1234);
        check("mis_sh_no_dw", 32'(bus.dw_data_addr_valid), 32'h0);
        check("mis_sh_done", 32'(bus.done_valid), 32'h1);
        check("mis_sh_err", 32'(bus.done_err), 32'h1);
        tick();
        check("mis_sh_still_no_dw", 32'(bus.dw_data_addr_valid), 32'h0);

        // stalled read address: valid and address stay put
        rd_ready_en = 1'b0;
        issue(1'b0, 3'b010, 32'h100, 32'h0);
        hold = 0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            if (bus.dr_addr_valid === 1'b1 && bus.dr_addr === 32'h100) hold++;
        end
        check("stall_hold_cycles", 32'(hold), 32'd6);
        rd_ready_en = 1'b1;
        wait_done();
        check("stall_rdata", bus.done_rdata, 32'h80FF7F01);
        check("stall_err", 32'(bus.done_err), 32'h0);

        // bus error response on a store
        resp_code = 2'd1;
        do_op("sw_resp_err", 1'b1, 3'b010, 32'h204, 32'h55, 32'h0, 2'd2);
        resp_code = 2'd0;

        // write response never arrives: abort after 8 cycles in WRESP
        resp_mute = 1'b1;
        issue(1'b1, 3'b010, 32'h208, 32'h77);
        wresp_cycles = 0;
        for (int i = 0; i < 40 && !bus.done_valid; i++) begin
            tick();
            if (bus.dw_resp_ready === 1'b1) wresp_cycles++;
        end
        check("to_done", 32'(bus.done_valid), 32'h1);
        check("to_err", 32'(bus.done_err), 32'h3);
        check("to_wresp_cycles", 32'(wresp_cycles), 32'd8);
        check("to_resp_ready_dropped", 32'(bus.dw_resp_ready), 32'h0);
        resp_mute = 1'b0;
        tick();

        // reset while waiting for read data
        issue(1'b0, 3'b010, 32'h100, 32'h0);
        tick();
        check("rr_in_rdata", 32'(bus.dr_data_ready), 32'h1);
        rst = 1'b0;
        tick();
        check("rr_data_ready", 32'(bus.dr_data_ready), 32'h0);
        check("rr_addr_valid", 32'(bus.dr_addr_valid), 32'h0);
        check("rr_done_valid", 32'(bus.done_valid), 32'h0);
        check("rr_req_ready", 32'(bus.req_ready), 32'h0);
        check("rr_dr_addr", bus.dr_addr, 32'h0);
        rst = 1'b1;
        tick();
        check("rr_after_done", 32'(bus.done_valid), 32'h0);
        check("rr_after_req_ready", 32'(bus.req_ready), 32'h1);

        // back-to-back with req_valid held: second accepted on the done cycle
        bus.req_write = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h100;
        bus.req_wdata = 32'h0; bus.req_valid = 1'b1;
        tick();
        bus.req_write = 1'b1; bus.req_addr = 32'h20C; bus.req_wdata = 32'hCAFEF00D;
        tick();
        tick();
        check("b2b_done_valid", 32'(bus.done_valid), 32'h1);
        check("b2b_done_rdata", bus.done_rdata, 32'h80FF7F01);
        check("b2b_req_ready", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = 1'b0;
        check("b2b_dw_valid", 32'(bus.dw_data_addr_valid), 32'h1);
        check("b2b_dw_addr", bus.dw_addr, 32'h20C);
        check("b2b_dw_strobe", 32'(bus.dw_strobe), 32'hF);
        check("b2b_dw_data", bus.dw_data, 32'hCAFEF00D);
        wait_done();
        check("b2b_sw_err", 32'(bus.done_err), 32'h0);
        do_op("lw_20c", 1'b0, 3'b010, 32'h20C, 32'h0, 32'hCAFEF00D, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lsu_bus_initiator.md
Name:
lsu_bus_initiator

Overview:
- Data-side bus master of the copperv core: takes one load/store request at a time from the execute stage and drives the dr (data read) and dw (data write) channels.
- Converts byte/half/word accesses into word-aligned bus transfers with byte strobes, then extracts and extends load data.
- Reports completion, load data and an error code back to the core; it is the initiator counterpart of the simulation memory responder.

Parameters:
RESP_WIDTH, 2, width of dw_resp.
RESP_OK, 0, dw_resp value meaning write OK; any other value is a bus error.
TIMEOUT, 255, max cycles waited at any single handshake before abort; 0 disables timeout.

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous reset, active-low
req_valid  in  1  core request valid
req_ready  out  1  high only in IDLE and rst high; request accepted when req_valid && req_ready
req_write  in  1  1=store, 0=load
req_funct3  in  3  RISC-V size code: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); stores use [1:0]
req_addr  in  32  byte address
req_wdata  in  32  store data, LSB-justified
done_valid  out  1  one-cycle completion pulse
done_err  out  2  0 ok, 1 misaligned, 2 bus resp error, 3 timeout; valid with done_valid
done_rdata  out  32  extended load data; 0 for stores and errors
dr_addr_valid  out  1  read address valid
dr_addr_ready  in  1  read address ready
dr_addr  out  32  word-aligned read address {addr[31:2],2'b00}
dr_data_valid  in  1  read data valid
dr_data_ready  out  1  read data ready
dr_data  in  32  read data word
dw_data_addr_valid  out  1  write address+data valid
dw_data_addr_ready  in  1  write address+data ready
dw_addr  out  32  word-aligned write address
dw_data  out  32  lane-shifted store data
dw_strobe  out  4  byte-lane enables
dw_resp_valid  in  1  write response valid
dw_resp_ready  out  1  write response ready
dw_resp  in  RESP_WIDTH  write response code

Behaviour:
- States: IDLE, RADDR, RDATA, WREQ, WRESP. On accept, latch write, funct3, addr and wdata. Bus outputs are driven only from latched values and stay stable while their valid is high.
- Misaligned request (H/HU/store-half with addr[0]=1, W with addr[1:0]!=0): no bus activity. Stay in IDLE; next cycle done_valid=1, done_err=1, and req_ready stays 1.
- Load: IDLE->RADDR (dr_addr_valid=1) -> on dr_addr_ready -> RDATA (dr_data_ready=1) -> on dr_data_valid, capture data and go to IDLE. done_valid pulses on the cycle after the data handshake, which is the same cycle req_ready is 1 again.
- Store: IDLE->WREQ (dw_data_addr_valid=1) -> on ready -> WRESP (dw_resp_ready=1) -> on dw_resp_valid -> IDLE. done pulses next cycle; done_err=2 if dw_resp!=RESP_OK.
- dr_data_ready is 0 outside RDATA and dw_resp_ready is 0 outside WRESP. The responder ORs instruction and data ready signals, so a stray ready is illegal.
- Latency against a zero-wait responder (address ready=1, data/response valid the cycle after the address handshake): accept at cycle N, done_valid at N+3.
- Lane math: off=addr[1:0].
  - Strobe: B=4'b0001<<off, H=4'b0011<<off, W=4'b1111.
  - dw_data: wdata[7:0] replicated to all lanes for B, wdata[15:0] replicated for H, wdata for W.
  - Load: shift dr_data right by 8*off, then sign-extend (B/H) or zero-extend (BU/HU) from bit 7/15.
- Timeout: 8-bit counter cleared on each state entry, incremented while a handshake is pending. When it reaches TIMEOUT, drop valid/ready, go to IDLE, and pulse done with err=3. TIMEOUT=0 means wait forever.
- Reset (rst=0 at a posedge, including mid-transaction): state IDLE and all outputs 0 (req_ready 0 while rst low); no done pulse for the aborted request.
- Reserved funct3 (011, 110, 111): treat as W.

Test Plan:
- LW addr 0x100, memory word 0x11223344 -> dr_addr=0x100, done_rdata=0x11223344, done_err=0, done_valid at accept+3.
- LB addr 0x103 (word 0x80FF7F01) -> 0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x102 -> 0xFFFF80FF; LHU addr 0x102 -> 0x000080FF.
- SB addr 0x201 wdata 0xAB -> dw_addr=0x200, dw_strobe=4'b0010, dw_data=0xABABABAB, done_err=0; reading back the word shows 0xAB only in byte 1.
- LW addr 0x102 -> no dr_addr_valid, done_valid next cycle with done_err=1; SH addr 0x301 -> same with no dw activity.
- Stall responder: dr_addr_ready low 5 cycles -> dr_addr_valid and dr_addr held stable; a response of 1 on a store -> done_err=2. TIMEOUT=8 with dw_resp_valid never asserted -> done_err=3 after 8 cycles in WRESP.
- Assert rst low in RDATA -> all outputs 0 next cycle, no done_valid. Back-to-back LW/SW with req_valid held high -> second accepted on the done cycle.
